// File: rtl/local_port_ni_pkg.sv
// Shared definitions for the local-port network interface: flit geometry,
// field offsets, the local direction index and the TX/RX state encodings.
// Default field widths come from HDR_SZ / PL_SZ / ADDR_SZ when a build provides them.

`ifndef HDR_SZ
`define HDR_SZ 2
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

package local_port_ni_pkg;

  // Router port index that the NI attaches to.
  localparam int unsigned LocalDir = 4;

  localparam int DefaultFlitW = `HDR_SZ + `PL_SZ + `ADDR_SZ;

  // Flit layout, MSB..LSB: {hdr, payload, dest}.
  function automatic int flit_width(int hdr_w, int pl_w, int addr_w);
    return hdr_w + pl_w + addr_w;
  endfunction

  function automatic int dest_lsb();
    return 0;
  endfunction

  function automatic int pl_lsb(int addr_w);
    return addr_w;
  endfunction

  function automatic int hdr_lsb(int pl_w, int addr_w);
    return addr_w + pl_w;
  endfunction

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxShift,
    TxGap
  } tx_state_e;

  typedef enum logic [1:0] {
    RxWait,
    RxShift,
    RxHold
  } rx_state_e;

endpackage

// File: rtl/local_port_ni_if.sv
// Signal bundle between the NI, its host and the router's local serial link.
// slave = the NI side, master = the host/router side.

interface local_port_ni_if
  import local_port_ni_pkg::*;
#(
  parameter int FLIT_W = DefaultFlitW
);

  logic              link_tx_busy;
  logic              link_tx_data;
  logic              link_rx_data;
  logic              link_rx_busy;
  logic              send_valid;
  logic              send_ready;
  logic [FLIT_W-1:0] send_flit;
  logic              recv_valid;
  logic              recv_ready;
  logic [FLIT_W-1:0] recv_flit;
  logic [15:0]       sent_count;
  logic [15:0]       recv_count;

  modport slave (
    input  link_tx_busy, link_rx_data, send_valid, send_flit, recv_ready,
    output link_tx_data, link_rx_busy, send_ready, recv_valid, recv_flit,
    output sent_count, recv_count
  );

  modport master (
    output link_tx_busy, link_rx_data, send_valid, send_flit, recv_ready,
    input  link_tx_data, link_rx_busy, send_ready, recv_valid, recv_flit,
    input  sent_count, recv_count
  );

endinterface

// File: rtl/local_port_ni_rx_deser.sv
// Serial-to-parallel receiver: waits for a start bit, shifts in FLIT_W bits
// LSB first, then holds the flit until the consumer takes it. busy_o tells
// the sender not to start another frame. With NI_STATS_EN a done_o pulse
// marks each completed frame.

module local_port_ni_rx_deser
  import local_port_ni_pkg::*;
#(
  parameter int FLIT_W = DefaultFlitW
) (
  input  logic              clk,
  input  logic              reset,
`ifdef NI_STATS_EN
  output logic              done_o,
`endif
  input  logic              rx_data_i,
  output logic              rx_busy_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [FLIT_W-1:0] flit_o
);

  localparam int CntW = $clog2(FLIT_W + 1);

  rx_state_e         state_q;
  logic [FLIT_W-1:0] shreg_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic              valid_q;
  logic              last_bit;

  assign last_bit = (cnt_q == CntW'(FLIT_W - 1));

  // Receive FSM with registered busy/valid; the shift register doubles as the held flit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RxWait;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        RxWait: begin
          if (rx_data_i) begin
            state_q <= RxShift;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        RxShift: begin
          shreg_q <= {rx_data_i, shreg_q[FLIT_W-1:1]};
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            state_q <= RxHold;
            valid_q <= 1'b1;
          end
        end
        RxHold: begin
          // Line is ignored here; the sender is expected to honour busy.
          if (ready_i) begin
            state_q <= RxWait;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RxWait;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef NI_STATS_EN
  assign done_o = (state_q == RxShift) && last_bit;
`endif

  assign rx_busy_o = busy_q;
  assign valid_o   = valid_q;
  assign flit_o    = shreg_q;

endmodule

// File: rtl/local_port_ni.sv
// Network interface for a router's local port. The TX path serializes host
// flits onto the router's local RX input (start bit 1, then LSB-first data,
// then at least one idle cycle); the RX path is local_port_ni_rx_deser.
// Optional flit statistics are enabled with the NI_STATS_EN macro.

module local_port_ni
  import local_port_ni_pkg::*;
#(
  parameter int NODE_ID = -1,
  parameter int HDR_W   = `HDR_SZ,
  parameter int PL_W    = `PL_SZ,
  parameter int ADDR_W  = `ADDR_SZ,
  parameter int FLIT_W  = flit_width(HDR_W, PL_W, ADDR_W)
) (
  input logic            clk,
  input logic            reset,
  local_port_ni_if.slave ni
);

  localparam int CntW = $clog2(FLIT_W + 1);

  tx_state_e         tx_state_q;
  logic [FLIT_W-1:0] tx_shreg_q;
  logic [CntW-1:0]   tx_cnt_q;
  logic              tx_data_q;
  logic              send_ready_q;
  logic              tx_last_bit;

  assign tx_last_bit = (tx_cnt_q == CntW'(FLIT_W - 1));

  // TX serializer. State names describe the action taken at the next edge:
  // Shift loads data bits, Gap means the last bit is on the line and the
  // following cycle is the mandatory idle gap, during which send_ready may
  // already be high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q   <= TxIdle;
      tx_shreg_q   <= '0;
      tx_cnt_q     <= '0;
      tx_data_q    <= 1'b0;
      send_ready_q <= 1'b0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          tx_data_q <= 1'b0;
          if (ni.send_valid && send_ready_q) begin
            tx_shreg_q   <= ni.send_flit;
            tx_data_q    <= 1'b1;
            send_ready_q <= 1'b0;
            tx_state_q   <= TxStart;
          end else begin
            send_ready_q <= !ni.link_tx_busy;
          end
        end
        TxStart: begin
          tx_data_q  <= tx_shreg_q[0];
          tx_shreg_q <= tx_shreg_q >> 1;
          tx_cnt_q   <= CntW'(1);
          tx_state_q <= TxShift;
        end
        TxShift: begin
          tx_data_q  <= tx_shreg_q[0];
          tx_shreg_q <= tx_shreg_q >> 1;
          tx_cnt_q   <= tx_cnt_q + 1'b1;
          if (tx_last_bit) begin
            tx_state_q <= TxGap;
          end
        end
        TxGap: begin
          tx_data_q    <= 1'b0;
          send_ready_q <= !ni.link_tx_busy;
          tx_state_q   <= TxIdle;
        end
        default: begin
          tx_data_q    <= 1'b0;
          send_ready_q <= 1'b0;
          tx_state_q   <= TxIdle;
        end
      endcase
    end
  end

  assign ni.link_tx_data = tx_data_q;
  assign ni.send_ready   = send_ready_q;

`ifdef NI_STATS_EN
  logic rx_done;
`endif

  local_port_ni_rx_deser #(
    .FLIT_W(FLIT_W)
  ) u_rx_deser (
    .clk       (clk),
    .reset     (reset),
`ifdef NI_STATS_EN
    .done_o    (rx_done),
`endif
    .rx_data_i (ni.link_rx_data),
    .rx_busy_o (ni.link_rx_busy),
    .valid_o   (ni.recv_valid),
    .ready_i   (ni.recv_ready),
    .flit_o    (ni.recv_flit)
  );

`ifdef NI_STATS_EN
  logic [15:0] sent_count_q, sent_count_d;
  logic [15:0] recv_count_q, recv_count_d;
  logic        tx_gap_enter;

  assign tx_gap_enter = (tx_state_q == TxShift) && tx_last_bit;

  // Saturating counters bumped on TX gap entry and RX hold entry.
  always_comb begin
    sent_count_d = sent_count_q;
    recv_count_d = recv_count_q;
    if (tx_gap_enter && (sent_count_q != 16'hFFFF)) begin
      sent_count_d = sent_count_q + 16'd1;
    end
    if (rx_done && (recv_count_q != 16'hFFFF)) begin
      recv_count_d = recv_count_q + 16'd1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_count_q <= '0;
      recv_count_q <= '0;
    end else begin
      sent_count_q <= sent_count_d;
      recv_count_q <= recv_count_d;
    end
  end

  assign ni.sent_count = sent_count_q;
  assign ni.recv_count = recv_count_q;
`else
  assign ni.sent_count = 16'd0;
  assign ni.recv_count = 16'd0;
`endif

  // send_ready must never be offered outside idle; tagged with the node id.
  assert property (@(posedge clk) disable iff (reset)
                   !(send_ready_q && (tx_state_q != TxIdle)))
    else $error("local_port_ni[%0d]: send_ready high outside idle", NODE_ID);

endmodule

// File: tb/tb_local_port_ni.sv
// Bench for local_port_ni with FLIT_W = 14. Stimulus pushes expected flits
// into queues; independent monitors decode the serial line and the receive
// handshake and compare against them.

module tb_local_port_ni;

  localparam int FW = 14;

  logic clk = 1'b0;
  logic reset;
  logic rx_drv;
  logic busy_drv;
  logic loop_en;

  int checks = 0;
  int errors = 0;
  int rx_got = 0;

  logic [FW-1:0] tx_exp_q[$];
  logic [FW-1:0] rx_exp_q[$];

  always #5 clk = ~clk;

  local_port_ni_if #(.FLIT_W(FW)) bus ();

  assign bus.link_rx_data = loop_en ? bus.link_tx_data : rx_drv;
  assign bus.link_tx_busy = loop_en ? bus.link_rx_busy : busy_drv;

  local_port_ni #(
    .NODE_ID (0),
    .HDR_W   (2),
    .PL_W    (8),
    .ADDR_W  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ni    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decode frames from the serial line: a 1 on an idle line is a start bit.
  task automatic tx_monitor();
    forever begin
      @(negedge clk);
      if (!reset && bus.link_tx_data) begin
        logic [FW-1:0] f;
        bit aborted;
        int i;
        f = '0;
        aborted = 0;
        i = 0;
        while (i < FW && !aborted) begin
          @(negedge clk);
          if (reset) aborted = 1;
          else f[i] = bus.link_tx_data;
          i++;
        end
        if (aborted) begin
          if (tx_exp_q.size() > 0) void'(tx_exp_q.pop_front());
        end else begin
          check("tx_expected_avail", (tx_exp_q.size() > 0), 1);
          if (tx_exp_q.size() > 0) check("tx_frame", f, tx_exp_q.pop_front());
          @(negedge clk);
          if (!reset) check("tx_gap", bus.link_tx_data, 0);
        end
      end
    end
  endtask

  // Compare each flit the host actually takes.
  task automatic rx_monitor();
    forever begin
      @(negedge clk);
      if (!reset && bus.recv_valid && bus.recv_ready) begin
        check("rx_expected_avail", (rx_exp_q.size() > 0), 1);
        if (rx_exp_q.size() > 0) check("rx_flit", bus.recv_flit, rx_exp_q.pop_front());
        rx_got++;
      end
    end
  endtask

  // Offer a flit; returns #1 after the accepting edge.
  task automatic send(input logic [FW-1:0] f);
    int n;
    n = 0;
    bus.send_flit  = f;
    bus.send_valid = 1'b1;
    while (!bus.send_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.send_ready) begin
      check("send_accept_timeout", bus.send_ready, 1);
      bus.send_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.send_valid = 1'b0;
      tx_exp_q.push_back(f);
      if (loop_en) rx_exp_q.push_back(f);
    end
  endtask

  // Drive a start bit then nbits of f, LSB first, onto the router->NI line.
  task automatic rx_frame(input logic [FW-1:0] f, input int nbits);
    if (nbits == FW) rx_exp_q.push_back(f);
    @(posedge clk);
    #1 rx_drv = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) check("rx_busy_rise", bus.link_rx_busy, 1);
      if (i == FW - 1) check("rx_valid_early", bus.recv_valid, 0);
      rx_drv = f[i];
    end
    if (nbits == FW) begin
      @(posedge clk);
      #1 rx_drv = 1'b0;
      check("rx_valid_at_s15", bus.recv_valid, 1);
    end
  endtask

  task automatic consume();
    @(posedge clk);
    #1 bus.recv_ready = 1'b1;
    @(posedge clk);
    #1 bus.recv_ready = 1'b0;
    check("rx_valid_drop", bus.recv_valid, 0);
    check("rx_busy_drop", bus.link_rx_busy, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.send_valid = 1'b0;
    bus.send_flit  = '0;
    bus.recv_ready = 1'b0;
    rx_drv   = 1'b0;
    busy_drv = 1'b0;
    loop_en  = 1'b0;
    reset    = 1'b1;
    fork
      tx_monitor();
      rx_monitor();
    join_none

    // Reset values and send_ready rising one clock after release.
    repeat (2) @(negedge clk);
    check("rst_tx_data", bus.link_tx_data, 0);
    check("rst_rx_busy", bus.link_rx_busy, 0);
    check("rst_send_ready", bus.send_ready, 0);
    check("rst_recv_valid", bus.recv_valid, 0);
    check("rst_recv_flit", bus.recv_flit, 0);
    check("rst_sent_count", bus.sent_count, 0);
    check("rst_recv_count", bus.recv_count, 0);
    #2 reset = 1'b0;
    #1 check("ready_before_clk", bus.send_ready, 0);
    @(posedge clk);
    #1 check("ready_first_clk", bus.send_ready, 1);

    // 1: single frame timing.
    send(14'h2A5C);
    @(negedge clk);
    check("t1_start_bit", bus.link_tx_data, 1);
    check("t1_ready_busy", bus.send_ready, 0);
    repeat (14) @(negedge clk);
    @(negedge clk);
    check("t1_gap_line", bus.link_tx_data, 0);
    check("t1_ready_t16", bus.send_ready, 1);

    // 2: back-pressure holds the flit until busy falls.
    busy_drv = 1'b1;
    repeat (2) @(negedge clk);
    bus.send_flit  = 14'h0B3D;
    bus.send_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t2_bp_ready", bus.send_ready, 0);
      check("t2_bp_line", bus.link_tx_data, 0);
    end
    busy_drv = 1'b0;
    tx_exp_q.push_back(14'h0B3D);
    @(negedge clk);
    check("t2_ready_after_busy", bus.send_ready, 1);
    check("t2_line_idle", bus.link_tx_data, 0);
    @(posedge clk);
    #1 bus.send_valid = 1'b0;
    @(negedge clk);
    check("t2_start_bit", bus.link_tx_data, 1);
    repeat (20) @(negedge clk);

    // 3: receive and hold until consumed.
    rx_frame(14'h1F03, FW);
    repeat (5) @(negedge clk);
    check("t3_hold_valid", bus.recv_valid, 1);
    check("t3_hold_flit", bus.recv_flit, 14'h1F03);
    check("t3_hold_busy", bus.link_rx_busy, 1);
    consume();

    // 4: reset in the middle of a TX and an RX frame.
    send(14'h3333);
    rx_frame(14'h1555, 7);
    @(negedge clk);
    #2 reset = 1'b1;
    rx_drv = 1'b0;
    #1;
    check("t4_line_zero", bus.link_tx_data, 0);
    check("t4_rx_busy_zero", bus.link_rx_busy, 0);
    check("t4_recv_valid_zero", bus.recv_valid, 0);
    check("t4_ready_zero", bus.send_ready, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    send(14'h24C6);
    rx_frame(14'h0E71, FW);
    consume();
    repeat (5) @(negedge clk);

    // 5: loopback of random flits with a randomly stalling consumer.
    pulse_reset();
    loop_en = 1'b1;
    begin
      int target;
      int cyc;
      target = rx_got + 100;
      cyc = 0;
      fork
        begin
          for (int k = 0; k < 100; k++) begin
            send(FW'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
          end
        end
        begin
          while (rx_got < target && cyc < 20000) begin
            @(posedge clk);
            #1 bus.recv_ready = 1'($urandom_range(0, 1));
            cyc++;
          end
          bus.recv_ready = 1'b0;
        end
      join
      check("t5_all_received", rx_got, target);
    end
    repeat (5) @(negedge clk);
    loop_en = 1'b0;
`ifdef NI_STATS_EN
    check("t5_sent_count", bus.sent_count, 100);
    check("t5_recv_count", bus.recv_count, 100);

    // 6: sent counter saturates.
    @(negedge clk);
    force dut.sent_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.sent_count_q;
    for (int k = 0; k < 3; k++) send(FW'($urandom));
    repeat (20) @(negedge clk);
    check("t6_sent_saturate", bus.sent_count, 16'hFFFF);
    check("t6_recv_unchanged", bus.recv_count, 100);
`else
    check("t5_sent_tied_zero", bus.sent_count, 0);
    check("t5_recv_tied_zero", bus.recv_count, 0);
`endif

    repeat (30) @(negedge clk);
    check("tx_queue_drained", tx_exp_q.size(), 0);
    check("rx_queue_drained", rx_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/local_port_ni.md
Name: local_port_ni

Overview:
- Network interface on a router's local port (bit 4). Other end of the router's local serial link.
- TX path: takes a parallel flit from the host or traffic generator and serializes it into the router's local RX input.
- RX path: deserializes flits from the router's local TX output and presents them to the host with a valid/ready handshake.
- One instance per router in the mesh top level.

Parameters:
- NODE_ID, -1, router/node id; used only in simulation $display tags.
- HDR_W, `HDR_SZ, header field width.
- PL_W, `PL_SZ, payload field width.
- ADDR_W, `ADDR_SZ, destination address width.
- FLIT_W, HDR_W+PL_W+ADDR_W, flit width. Field order MSB..LSB: {hdr, payload, dest}.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- link_tx_busy  input  1  router rx_busy[4]; high = router cannot accept a new frame.
- link_tx_data  output  1  serial out to router rx_data[4].
- link_rx_data  input  1  serial in from router tx_data[4].
- link_rx_busy  output  1  to router tx_busy[4]; high = NI holds an unconsumed flit or is receiving one.
- send_valid  input  1  host has a flit to send.
- send_ready  output  1  NI can accept a flit.
- send_flit  input  FLIT_W  flit to send.
- recv_valid  output  1  received flit available.
- recv_ready  input  1  host consumes the received flit.
- recv_flit  output  FLIT_W  received flit.
- sent_count  output  16  flits sent (NI_STATS_EN).
- recv_count  output  16  flits received (NI_STATS_EN).

Behaviour:
- Link frame format:
  - Idle line = 0.
  - Frame = start bit 1, then FLIT_W data bits LSB first, one bit per clk.
  - Minimum one idle cycle between frames.
- Reset values: link_tx_data=0, link_rx_busy=0, send_ready=0, recv_valid=0, recv_flit=0, counters=0.
- send_ready rises the first clk after reset deasserts.
- TX FSM, states IDLE, START, SHIFT, GAP:
  - IDLE: send_ready = !link_tx_busy. On send_valid && send_ready at edge T: latch send_flit, go to START.
  - START: link_tx_data=1 during cycle T+1.
  - SHIFT: bit i is driven in cycle T+2+i, i = 0..FLIT_W-1. Bit counter is $clog2(FLIT_W+1) wide.
  - GAP: line 0 for one cycle, then IDLE. send_ready may return high at cycle T+2+FLIT_W.
  - send_ready=0 in every state except IDLE.
  - link_tx_busy is sampled only in IDLE. It is ignored mid-frame; the frame always completes.
- RX FSM, states WAIT, SHIFT, HOLD:
  - WAIT: on link_rx_data=1 sampled at edge S, go to SHIFT. link_rx_busy rises at S+1.
  - SHIFT: capture FLIT_W bits at edges S+1..S+FLIT_W into a shift register, LSB first.
  - HOLD: recv_valid=1 from cycle S+FLIT_W+1. recv_flit is stable while recv_valid=1.
  - On recv_valid && recv_ready: go to WAIT. recv_valid and link_rx_busy drop the next cycle.
  - link_rx_busy is high in SHIFT and HOLD, low in WAIT.
  - While in HOLD the line is ignored; the router must honour busy.
- TX and RX paths are fully independent. Simultaneous send and receive is legal with no interaction.
- Reset mid-frame: both FSMs go to idle immediately. A partial flit is discarded and the line returns to 0 asynchronously.
- Back-pressure: send_valid held with link_tx_busy=1 keeps the NI in IDLE with send_ready=0. No flit is lost.

Optional Feature:
- Macro NI_STATS_EN.
- Defined:
  - sent_count increments at each TX GAP entry.
  - recv_count increments at each RX HOLD entry.
  - Both are 16-bit and saturate at 0xFFFF.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package/include:
  - FLIT_W derivation, field offsets (DEST_LSB, PL_LSB, HDR_LSB).
  - Local direction index 4.
  - TX and RX state encodings.
- One natural sub-module: ni_rx_deser (RX FSM plus shift register plus HOLD). It is reusable by the router's rx.
- The TX path stays inline.

Test Plan (bench overrides HDR_W=2, PL_W=8, ADDR_W=4, so FLIT_W=14):
1. Send flit 14'h2A5C with link_tx_busy=0, accepted at T -> link_tx_data =1 at T+1, bits 0,0,1,1,1,0,1,0,0,1,0,1,0,1 over T+2..T+15, 0 at T+16; send_ready high at T+16.
2. link_tx_busy=1 for 20 cycles with send_valid=1 -> send_ready=0 and line 0 throughout; frame starts 2 cycles after busy falls (accept edge, then start bit).
3. Drive start bit plus 14'h1F03 LSB first, recv_ready=0 -> recv_valid=1 and recv_flit=14'h1F03 at S+15; link_rx_busy=1 from S+1; after recv_ready pulse, both fall the next cycle.
4. Assert reset at bit 7 of a TX and an RX frame -> line 0, link_rx_busy 0, recv_valid 0; then a subsequent full frame round-trips correctly.
5. Loop link_tx_data back to link_rx_data (busy inputs crossed) and send 100 random flits -> all received in order; with NI_STATS_EN, sent_count=recv_count=100.
6. With NI_STATS_EN, force sent_count to 0xFFFE, send 3 flits -> sent_count holds 0xFFFF.
